// File: rtl/pixel_accel_pkg.sv
// Shared types and per-byte colour arithmetic for the pixel stream accelerator.
package pixel_accel_pkg;

    localparam int COLOR_SIZE = 8;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BRIGHT = 2'd1,
        MODE_DARK   = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Nine-bit sum/difference so the carry or borrow bit drives the clamp.
    function automatic logic [COLOR_SIZE-1:0] proc_byte(input mode_e                 mode,
                                                        input logic [COLOR_SIZE-1:0] b,
                                                        input logic [COLOR_SIZE-1:0] pv);
        logic [COLOR_SIZE:0]   sum;
        logic [COLOR_SIZE:0]   diff;
        logic [COLOR_SIZE-1:0] result;
        sum  = {1'b0, b} + {1'b0, pv};
        diff = {1'b0, b} - {1'b0, pv};
        case (mode)
            MODE_PASS:   result = b;
            MODE_BRIGHT: result = sum[COLOR_SIZE]  ? '1 : sum[COLOR_SIZE-1:0];
            MODE_DARK:   result = diff[COLOR_SIZE] ? '0 : diff[COLOR_SIZE-1:0];
            default:     result = (b >= pv) ? '1 : '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pixel_stream_fifo.sv
// Show-ahead output FIFO: head entry is visible combinationally while not empty.
module pixel_stream_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (r_count != L_DEPTH);

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // rst_n is active-high here: a 1 clears state on the next rising edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/pixel_stream_accelerator.sv
// Round-robin frame arbiter, two-stage byte processor and output FIFO feeding one master.
module pixel_stream_accelerator
    import pixel_accel_pkg::*;
#(
    parameter int NUM_SLV    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int SRC_W      = $clog2(NUM_SLV)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*NUM_SLV-1:0]          slv_mode,
    input  logic [8*NUM_SLV-1:0]          slv_proc_val,
    input  logic [DATA_WIDTH*NUM_SLV-1:0] slv_data,
    input  logic [NUM_SLV-1:0]            slv_data_valid,
    input  logic [NUM_SLV-1:0]            slv_last,
    output logic [NUM_SLV-1:0]            slv_ready,
    input  logic                          mstr0_ready,
    output logic [DATA_WIDTH-1:0]         mstr0_data,
    output logic                          mstr0_data_valid,
    output logic                          mstr0_last,
    output logic [SRC_W-1:0]              mstr0_src,
    output logic                          mstr0_cmplt
);
    localparam int NBYTES = DATA_WIDTH / COLOR_SIZE;
    localparam int FW     = DATA_WIDTH + SRC_W + 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(FIFO_DEPTH);

    state_e                r_state, w_state_nxt;
    logic [SRC_W-1:0]      r_grant, r_rr_ptr, w_req_idx;
    logic                  w_req_found, w_grant_load, w_accept, w_credit_ok, w_last_accept;
    mode_e                 r_mode;
    logic [7:0]            r_pv;
    logic                  r_s1_valid, r_s1_last, r_s2_valid, r_s2_last;
    logic [DATA_WIDTH-1:0] r_s1_data, r_s2_data, w_proc_data;
    logic [SRC_W-1:0]      r_s1_src, r_s2_src;
    logic [FW-1:0]         w_fifo_head;
    logic                  w_fifo_empty, w_pop_fire;
    logic [CW-1:0]         w_fifo_count;
    logic [CW:0]           w_occupancy;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [SRC_W-1:0]      r_hold_src;
    logic                  r_cmplt;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            int idx;
            idx = (int'(r_rr_ptr) + i) % NUM_SLV;
            if (!w_req_found && slv_data_valid[idx]) begin
                w_req_found = 1'b1;
                w_req_idx   = SRC_W'(idx);
            end
        end
    end

    // Pipeline stages count against the FIFO so a full FIFO can never be overrun.
    assign w_occupancy   = (CW+1)'(w_fifo_count) + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
    assign w_credit_ok   = (w_occupancy < L_DEPTH);
    assign w_accept      = (r_state == ST_STREAM) && w_credit_ok && slv_data_valid[r_grant];
    assign w_last_accept = w_accept && slv_last[r_grant];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_load = 1'b0;
        slv_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_nxt  = ST_STREAM;
                    w_grant_load = 1'b1;
                end
            end
            ST_STREAM: begin
                slv_ready[r_grant] = w_credit_ok;
                if (w_last_accept) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_mode   <= MODE_PASS;
            r_pv     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_load) begin
                r_grant <= w_req_idx;
                r_mode  <= mode_e'(slv_mode[2*int'(w_req_idx) +: 2]);
                r_pv    <= slv_proc_val[8*int'(w_req_idx) +: 8];
            end
            if (w_last_accept)
                r_rr_ptr <= (r_grant == SRC_W'(NUM_SLV-1)) ? '0 : r_grant + 1'b1;
        end
    end

    // r_mode is still the old frame's value when its last beat leaves stage 1:
    // the next grant loads on that same edge, and its first beat arrives one cycle later.
    always_comb begin
        w_proc_data = '0;
        for (int b = 0; b < NBYTES; b++)
            w_proc_data[b*COLOR_SIZE +: COLOR_SIZE] =
                proc_byte(r_mode, r_s1_data[b*COLOR_SIZE +: COLOR_SIZE], r_pv);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_src   <= '0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_src   <= '0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_last  <= slv_last[r_grant];
            r_s1_src   <= r_grant;
            r_s1_data  <= slv_data[DATA_WIDTH*int'(r_grant) +: DATA_WIDTH];
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_src   <= r_s1_src;
            r_s2_data  <= w_proc_data;
        end
    end

    pixel_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_s2_valid),
        .i_push_data ({r_s2_last, r_s2_src, r_s2_data}),
        .i_pop       (mstr0_ready),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_pop_fire       = !w_fifo_empty && mstr0_ready;
    assign mstr0_data_valid = !w_fifo_empty;
    assign mstr0_last       = !w_fifo_empty && w_fifo_head[FW-1];
    assign mstr0_data       = w_fifo_empty ? r_hold_data : w_fifo_head[DATA_WIDTH-1:0];
    assign mstr0_src        = w_fifo_empty ? r_hold_src  : w_fifo_head[DATA_WIDTH +: SRC_W];
    assign mstr0_cmplt      = r_cmplt;

    // Last popped beat is held so the data bus stays stable while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_hold_data <= '0;
            r_hold_src  <= '0;
            r_cmplt     <= 1'b0;
        end else begin
            r_cmplt <= w_pop_fire && w_fifo_head[FW-1];
            if (w_pop_fire) begin
                r_hold_data <= w_fifo_head[DATA_WIDTH-1:0];
                r_hold_src  <= w_fifo_head[DATA_WIDTH +: SRC_W];
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_accelerator.sv
// Directed bench: mode table, round-robin order, latency, backpressure, mode latch, mid-frame reset.
module tb_pixel_stream_accelerator;
    localparam int NUM_SLV = 4;
    localparam int DW      = 32;
    localparam int SRC_W   = 2;
    localparam int NV      = 10;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [2*NUM_SLV-1:0]  slv_mode;
    logic [8*NUM_SLV-1:0]  slv_proc_val;
    logic [DW*NUM_SLV-1:0] slv_data;
    logic [NUM_SLV-1:0]    slv_data_valid;
    logic [NUM_SLV-1:0]    slv_last;
    logic [NUM_SLV-1:0]    slv_ready;
    logic                  mstr0_ready;
    logic [DW-1:0]         mstr0_data;
    logic                  mstr0_data_valid;
    logic                  mstr0_last;
    logic [SRC_W-1:0]      mstr0_src;
    logic                  mstr0_cmplt;

    typedef struct { logic [DW-1:0] data; logic [SRC_W-1:0] src; logic last; } out_t;
    typedef struct { int ch; logic [1:0] mode; logic [7:0] pv; logic [DW-1:0] din; logic [DW-1:0] exp; } vec_t;

    out_t out_q[$];
    vec_t vecs[NV];
    int   rr_src[6] = '{0, 0, 2, 2, 3, 3};
    int   n_checks = 0;
    int   n_fail = 0;
    int   cmplt_cnt = 0;
    int   acc_cnt = 0;
    int   multi_ready = 0;
    int   c0;

    pixel_stream_accelerator #(
        .NUM_SLV    (NUM_SLV),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .slv_mode         (slv_mode),
        .slv_proc_val     (slv_proc_val),
        .slv_data         (slv_data),
        .slv_data_valid   (slv_data_valid),
        .slv_last         (slv_last),
        .slv_ready        (slv_ready),
        .mstr0_ready      (mstr0_ready),
        .mstr0_data       (mstr0_data),
        .mstr0_data_valid (mstr0_data_valid),
        .mstr0_last       (mstr0_last),
        .mstr0_src        (mstr0_src),
        .mstr0_cmplt      (mstr0_cmplt)
    );

    always #5 clk = ~clk;

    // Sample mid-cycle, after inputs settle and well before the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            if (mstr0_data_valid && mstr0_ready) begin
                out_t o;
                o.data = mstr0_data;
                o.src  = mstr0_src;
                o.last = mstr0_last;
                out_q.push_back(o);
            end
            if (mstr0_cmplt) cmplt_cnt++;
            acc_cnt += $countones(slv_data_valid & slv_ready);
            if ($countones(slv_ready) > 1) multi_ready++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is taken.
    task automatic drive_beat(input int ch, input logic [1:0] m, input logic [7:0] pv,
                              input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        slv_mode[2*ch +: 2]     = m;
        slv_proc_val[8*ch +: 8] = pv;
        slv_data[DW*ch +: DW]   = d;
        slv_last[ch]            = l;
        slv_data_valid[ch]      = 1'b1;
        #1;
        while (!slv_ready[ch] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("beat_accept", slv_ready[ch], 1'b1);
        @(negedge clk);
        slv_data_valid[ch] = 1'b0;
        slv_last[ch]       = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int t = 0; t < 100 && out_q.size() < n; t++) begin
            @(negedge clk);
            #3;
        end
        check("out_count", out_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 2'd0, 8'h20, 32'h1080F0FF, 32'h1080F0FF};
        vecs[1] = '{1, 2'd1, 8'h20, 32'h1080F0FF, 32'h30A0FFFF};
        vecs[2] = '{2, 2'd2, 8'h20, 32'h1080F0FF, 32'h0060D0DF};
        vecs[3] = '{3, 2'd3, 8'h20, 32'h1080F0FF, 32'h00FFFFFF};
        vecs[4] = '{0, 2'd3, 8'h80, 32'h7F808100, 32'h00FFFF00};
        vecs[5] = '{1, 2'd1, 8'h01, 32'hFEFF007F, 32'hFFFF0180};
        vecs[6] = '{2, 2'd2, 8'hFF, 32'hFFFE0080, 32'h00000000};
        vecs[7] = '{3, 2'd1, 8'h00, 32'h12345678, 32'h12345678};
        vecs[8] = '{0, 2'd3, 8'h00, 32'h0001FF55, 32'hFFFFFFFF};
        vecs[9] = '{1, 2'd2, 8'h01, 32'h010002FF, 32'h000001FE};

        rst_n = 1'b1;
        slv_mode = '0;
        slv_proc_val = '0;
        slv_data = '0;
        slv_data_valid = '0;
        slv_last = '0;
        mstr0_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_slv_ready", slv_ready, 4'b0000);
        check("rst_valid", mstr0_data_valid, 1'b0);
        check("rst_last", mstr0_last, 1'b0);
        check("rst_cmplt", mstr0_cmplt, 1'b0);
        check("rst_data", mstr0_data, 32'h0);
        check("rst_src", mstr0_src, 2'd0);
        rst_n = 1'b0;

        // Round-robin across ch0, ch2, ch3 with two-beat frames.
        @(negedge clk);
        fork
            begin drive_beat(0, 2'd0, 8'h00, 32'hC0000000, 1'b0); drive_beat(0, 2'd0, 8'h00, 32'hC0000001, 1'b1); end
            begin drive_beat(2, 2'd0, 8'h00, 32'hC2000000, 1'b0); drive_beat(2, 2'd0, 8'h00, 32'hC2000001, 1'b1); end
            begin drive_beat(3, 2'd0, 8'h00, 32'hC3000000, 1'b0); drive_beat(3, 2'd0, 8'h00, 32'hC3000001, 1'b1); end
        join
        wait_out(6);
        for (int k = 0; k < 6; k++) begin
            if (k < out_q.size()) begin
                check("rr_src", out_q[k].src, rr_src[k]);
                check("rr_data", out_q[k].data, 32'hC0000000 | (rr_src[k] << 24) | (k % 2));
                check("rr_last", out_q[k].last, (k % 2) == 1);
            end
        end
        repeat (4) @(negedge clk);
        #3;
        check("rr_cmplt_pulses", cmplt_cnt, 3);

        // Latency of a single-beat frame into an empty FIFO.
        out_q.delete();
        @(negedge clk);
        drive_beat(0, 2'd0, 8'h00, 32'hA5A50001, 1'b1);
        #1 check("lat_t0_valid", mstr0_data_valid, 1'b0);
        @(negedge clk);
        #1 check("lat_t1_valid", mstr0_data_valid, 1'b0);
        @(negedge clk);
        #1;
        check("lat_t2_valid", mstr0_data_valid, 1'b1);
        check("lat_t2_data", mstr0_data, 32'hA5A50001);
        check("lat_t2_last", mstr0_last, 1'b1);
        check("lat_t2_cmplt", mstr0_cmplt, 1'b0);
        @(negedge clk);
        #1;
        check("lat_t3_valid", mstr0_data_valid, 1'b0);
        check("lat_t3_cmplt", mstr0_cmplt, 1'b1);
        check("lat_hold_data", mstr0_data, 32'hA5A50001);
        @(negedge clk);
        #1 check("lat_t4_cmplt", mstr0_cmplt, 1'b0);

        // Mode table, one single-beat frame per vector.
        out_q.delete();
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive_beat(vecs[k].ch, vecs[k].mode, vecs[k].pv, vecs[k].din, 1'b1);
            wait_out(1);
            if (out_q.size() > 0) begin
                out_t o;
                o = out_q.pop_front();
                check($sformatf("vec%0d_data", k), o.data, vecs[k].exp);
                check($sformatf("vec%0d_src", k), o.src, vecs[k].ch);
                check($sformatf("vec%0d_last", k), o.last, 1'b1);
            end
        end

        // Mode and operand changes after the grant must not affect the frame.
        out_q.delete();
        @(negedge clk);
        drive_beat(1, 2'd1, 8'h10, 32'h0010F880, 1'b0);
        drive_beat(1, 2'd3, 8'h50, 32'h0010F880, 1'b0);
        drive_beat(1, 2'd3, 8'h50, 32'h0010F880, 1'b1);
        wait_out(3);
        for (int k = 0; k < 3; k++) begin
            if (k < out_q.size()) begin
                check("latch_data", out_q[k].data, 32'h1020FF90);
                check("latch_last", out_q[k].last, k == 2);
            end
        end

        // Backpressure: 20-beat frame against a stalled master.
        repeat (4) @(negedge clk);
        out_q.delete();
        acc_cnt = 0;
        c0 = cmplt_cnt;
        mstr0_ready = 1'b0;
        fork
            for (int i = 0; i < 20; i++) drive_beat(0, 2'd0, 8'h00, 32'hB0000000 + i, i == 19);
            begin
                repeat (30) @(negedge clk);
                #3;
                check("bp_accepted", acc_cnt, 8);
                check("bp_ready_low", slv_ready[0], 1'b0);
                check("bp_no_output", out_q.size(), 0);
                @(negedge clk);
                mstr0_ready = 1'b1;
            end
        join
        wait_out(20);
        for (int k = 0; k < 20; k++) begin
            if (k < out_q.size()) begin
                check("bp_data", out_q[k].data, 32'hB0000000 + k);
                check("bp_last", out_q[k].last, k == 19);
            end
        end
        repeat (4) @(negedge clk);
        #3;
        check("bp_cmplt", cmplt_cnt, c0 + 1);

        // Mid-frame reset: leave rr pointing at ch3, stream ch1, then reset.
        @(negedge clk);
        out_q.delete();
        drive_beat(2, 2'd0, 8'h00, 32'h22220000, 1'b1);
        wait_out(1);
        repeat (4) @(negedge clk);
        out_q.delete();
        c0 = cmplt_cnt;
        drive_beat(1, 2'd0, 8'h00, 32'h11110001, 1'b0);
        drive_beat(1, 2'd0, 8'h00, 32'h11110002, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", mstr0_data_valid, 1'b0);
        check("mrst_data", mstr0_data, 32'h0);
        check("mrst_src", mstr0_src, 2'd0);
        check("mrst_last", mstr0_last, 1'b0);
        check("mrst_ready", slv_ready, 4'b0000);
        repeat (6) @(negedge clk);
        #3;
        check("mrst_no_output", out_q.size(), 0);
        check("mrst_no_cmplt", cmplt_cnt, c0);
        @(negedge clk);
        fork
            drive_beat(3, 2'd0, 8'h00, 32'h33330000, 1'b1);
            drive_beat(2, 2'd0, 8'h00, 32'h22220002, 1'b1);
        join
        wait_out(2);
        if (out_q.size() >= 2) begin
            check("mrst_first_src", out_q[0].src, 2'd2);
            check("mrst_first_data", out_q[0].data, 32'h22220002);
            check("mrst_second_src", out_q[1].src, 2'd3);
            check("mrst_second_data", out_q[1].data, 32'h33330000);
        end

        check("ready_onehot", multi_ready, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
